memory_access: RTL and testbench

- Pipeline stage directly downstream of the execute stage. Consumes the registered execute outputs: ALU result/effective address, forwarded instruction, rd and rs2 data.
- For LOAD/STORE it runs a req/ack transaction on the data-memory port, handling byte lanes, alignment and sign extension.
- For all other opcodes it registers the ALU result through unchanged.
- Stalls upstream while a memory transaction is outstanding. Feeds the writeback stage.

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/load_extract.sv | 34 +++
 rtl/memory_access.sv | 226 ++++++++++++++++++++++
 tb/tb_memory_access.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V constants and the memory-stage FSM state type.
package riscv_pkg;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } mem_state_t;

endpackage

// File: rtl/load_extract.sv
// Selects the addressed byte/halfword of a load word and sign- or zero-extends it.
module load_extract
  import riscv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (addr)
      2'd0:    w_byte = rdata[7:0];
      2'd1:    w_byte = rdata[15:8];
      2'd2:    w_byte = rdata[23:16];
      default: w_byte = rdata[31:24];
    endcase
    w_half = addr[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    case (funct3)
      F3_B:    result = {{24{w_byte[7]}}, w_byte};
      F3_H:    result = {{16{w_half[15]}}, w_half};
      F3_BU:   result = {24'd0, w_byte};
      F3_HU:   result = {16'd0, w_half};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// Memory pipeline stage: runs LOAD/STORE req/ack transactions on the data port,
// passes all other results through, and stalls upstream while a transaction is open.
module memory_access
  import riscv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk_100MHz,
  input  logic        reset,
  input  logic [31:0] instruction_fetched_R1,
  input  logic [31:0] data_out_exe,
  input  logic [4:0]  rd_1,
  input  logic [31:0] data_rs2_R1,
  output logic        stall_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] instruction_fetched_R2,
  output logic [4:0]  rd_2,
  output logic [31:0] data_out_mem,
  output logic        mem_err
);

  localparam int              CNT_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  // Decode of the instruction presented by execute
  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic        w_is_load;
  logic        w_is_store;
  logic        w_mem_op;
  logic        w_legal_f3;
  logic        w_misaligned;
  logic        w_bad;
  logic [3:0]  w_lane_be;
  logic [31:0] w_lane_wdata;
  logic [31:0] w_load_data;
  logic        w_timeout;

  mem_state_t  r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic        r_req, w_req_nxt;
  logic        r_we, w_we_nxt;
  logic [31:0] r_addr, w_addr_nxt;
  logic [3:0]  r_be, w_be_nxt;
  logic [31:0] r_wdata, w_wdata_nxt;
  logic [1:0]  r_lane, w_lane_nxt;
  logic [2:0]  r_f3, w_f3_nxt;
  logic [31:0] r_instr, w_instr_nxt;
  logic [4:0]  r_rd, w_rd_nxt;
  logic [31:0] r_data, w_data_nxt;
  logic        r_err, w_err_nxt;
  logic        w_stall;

  assign w_opcode   = instruction_fetched_R1[6:0];
  assign w_funct3   = instruction_fetched_R1[14:12];
  assign w_is_load  = (w_opcode == LOAD);
  assign w_is_store = (w_opcode == STORE);
  assign w_mem_op   = w_is_load | w_is_store;

  always_comb begin
    w_legal_f3 = 1'b0;
    if (w_is_load) begin
      case (w_funct3)
        F3_B, F3_H, F3_W, F3_BU, F3_HU: w_legal_f3 = 1'b1;
        default:                        w_legal_f3 = 1'b0;
      endcase
    end else if (w_is_store) begin
      case (w_funct3)
        F3_B, F3_H, F3_W: w_legal_f3 = 1'b1;
        default:          w_legal_f3 = 1'b0;
      endcase
    end
  end

  // Among legal funct3 values, [1:0]==10 is a word and [1:0]==01 a halfword
  assign w_misaligned = ((w_funct3[1:0] == 2'b10) && (data_out_exe[1:0] != 2'b00)) ||
                        ((w_funct3[1:0] == 2'b01) && data_out_exe[0]);
  assign w_bad        = w_mem_op & (~w_legal_f3 | w_misaligned);

  always_comb begin
    w_lane_be    = 4'b1111;
    w_lane_wdata = '0;
    if (w_is_store) begin
      case (w_funct3)
        F3_B: begin
          w_lane_be    = 4'b0001 << data_out_exe[1:0];
          w_lane_wdata = {4{data_rs2_R1[7:0]}};
        end
        F3_H: begin
          w_lane_be    = data_out_exe[1] ? 4'b1100 : 4'b0011;
          w_lane_wdata = {2{data_rs2_R1[15:0]}};
        end
        default: w_lane_wdata = data_rs2_R1;
      endcase
    end
  end

  load_extract u_load_extract (
    .rdata  (dmem_rdata),
    .addr   (r_lane),
    .funct3 (r_f3),
    .result (w_load_data)
  );

  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST);

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned; a missed default here would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_req_nxt   = r_req;
    w_we_nxt    = r_we;
    w_addr_nxt  = r_addr;
    w_be_nxt    = r_be;
    w_wdata_nxt = r_wdata;
    w_lane_nxt  = r_lane;
    w_f3_nxt    = r_f3;
    w_instr_nxt = '0;
    w_rd_nxt    = '0;
    w_data_nxt  = '0;
    w_err_nxt   = 1'b0;
    w_stall     = 1'b0;

    case (r_state)
      IDLE: begin
        if (!w_mem_op) begin
          w_instr_nxt = instruction_fetched_R1;
          w_rd_nxt    = rd_1;
          w_data_nxt  = data_out_exe;
        end else if (w_bad) begin
          w_instr_nxt = instruction_fetched_R1;
          w_err_nxt   = 1'b1;
        end else begin
          w_stall     = 1'b1;
          w_state_nxt = REQ;
          w_cnt_nxt   = '0;
          w_req_nxt   = 1'b1;
          w_we_nxt    = w_is_store;
          w_addr_nxt  = {data_out_exe[31:2], 2'b00};
          w_be_nxt    = w_lane_be;
          w_wdata_nxt = w_lane_wdata;
          w_lane_nxt  = data_out_exe[1:0];
          w_f3_nxt    = w_funct3;
        end
      end

      REQ: begin
        if (dmem_ack) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_req_nxt   = 1'b0;
          w_instr_nxt = instruction_fetched_R1;
          if (!r_we) begin
            w_rd_nxt   = rd_1;
            w_data_nxt = w_load_data;
          end
        end else if (w_timeout) begin
          // Release upstream so the faulting instruction retires with mem_err
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_req_nxt   = 1'b0;
          w_instr_nxt = instruction_fetched_R1;
          w_err_nxt   = 1'b1;
        end else begin
          w_stall   = 1'b1;
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_be    <= '0;
      r_wdata <= '0;
      r_lane  <= '0;
      r_f3    <= '0;
      r_instr <= '0;
      r_rd    <= '0;
      r_data  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_req   <= w_req_nxt;
      r_we    <= w_we_nxt;
      r_addr  <= w_addr_nxt;
      r_be    <= w_be_nxt;
      r_wdata <= w_wdata_nxt;
      r_lane  <= w_lane_nxt;
      r_f3    <= w_f3_nxt;
      r_instr <= w_instr_nxt;
      r_rd    <= w_rd_nxt;
      r_data  <= w_data_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign stall_mem              = w_stall;
  assign dmem_req               = r_req;
  assign dmem_we                = r_we;
  assign dmem_addr              = r_addr;
  assign dmem_be                = r_be;
  assign dmem_wdata             = r_wdata;
  assign instruction_fetched_R2 = r_instr;
  assign rd_2                   = r_rd;
  assign data_out_mem           = r_data;
  assign mem_err                = r_err;

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: pass-through, load/store table, error,
// timeout and reset-abort sequences against hand-computed values.
module tb_memory_access;
  import riscv_pkg::*;

  logic        clk_100MHz = 1'b0;
  logic        reset;
  logic [31:0] instruction_fetched_R1;
  logic [31:0] data_out_exe;
  logic [4:0]  rd_1;
  logic [31:0] data_rs2_R1;
  logic        stall_mem;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [31:0] instruction_fetched_R2;
  logic [4:0]  rd_2;
  logic [31:0] data_out_mem;
  logic        mem_err;

  int n_checks = 0;
  int n_errors = 0;

  memory_access #(.TIMEOUT_CYCLES(4)) dut (
    .clk_100MHz             (clk_100MHz),
    .reset                  (reset),
    .instruction_fetched_R1 (instruction_fetched_R1),
    .data_out_exe           (data_out_exe),
    .rd_1                   (rd_1),
    .data_rs2_R1            (data_rs2_R1),
    .stall_mem              (stall_mem),
    .dmem_req               (dmem_req),
    .dmem_we                (dmem_we),
    .dmem_addr              (dmem_addr),
    .dmem_be                (dmem_be),
    .dmem_wdata             (dmem_wdata),
    .dmem_ack               (dmem_ack),
    .dmem_rdata             (dmem_rdata),
    .instruction_fetched_R2 (instruction_fetched_R2),
    .rd_2                   (rd_2),
    .data_out_mem           (data_out_mem),
    .mem_err                (mem_err)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [31:0] rdata;
    int          waits;
    logic        exp_err;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_data;
  } mem_vec_t;

  mem_vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] data,
                       input logic [4:0] rd, input logic [31:0] rs2);
    instruction_fetched_R1 = instr;
    data_out_exe           = data;
    rd_1                   = rd;
    data_rs2_R1            = rs2;
  endtask

  function automatic logic [31:0] enc(input logic [6:0] op, input logic [2:0] f3);
    return {17'd0, f3, 5'd7, op};
  endfunction

  task automatic run_mem(input int idx, input mem_vec_t v);
    logic [31:0] instr;
    int          stalls;
    logic        is_store;
    instr    = enc(v.op, v.f3);
    is_store = (v.op == STORE);
    drive(instr, v.addr, 5'd7, v.rs2);
    dmem_ack = 1'b0;
    #1;
    if (v.exp_err) begin
      check($sformatf("v%0d err_stall", idx), stall_mem, 0);
      step();
      check($sformatf("v%0d err_pulse", idx), mem_err, 1);
      check($sformatf("v%0d err_rd", idx), rd_2, 0);
      check($sformatf("v%0d err_data", idx), data_out_mem, 0);
      check($sformatf("v%0d err_noreq", idx), dmem_req, 0);
      check($sformatf("v%0d err_r2", idx), instruction_fetched_R2, instr);
      drive(32'd0, 32'd0, 5'd0, 32'd0);
      step();
      check($sformatf("v%0d err_once", idx), mem_err, 0);
    end else begin
      stalls = 0;
      if (stall_mem) stalls++;
      step();
      check($sformatf("v%0d req", idx), dmem_req, 1);
      check($sformatf("v%0d addr", idx), dmem_addr, v.exp_addr);
      check($sformatf("v%0d be", idx), dmem_be, v.exp_be);
      check($sformatf("v%0d we", idx), dmem_we, is_store);
      if (is_store) check($sformatf("v%0d wdata", idx), dmem_wdata, v.exp_wdata);
      check($sformatf("v%0d bubble_rd", idx), rd_2, 0);
      for (int i = 0; i < v.waits; i++) begin
        if (stall_mem) stalls++;
        step();
        check($sformatf("v%0d req_hold", idx), dmem_req, 1);
        check($sformatf("v%0d addr_hold", idx), dmem_addr, v.exp_addr);
        check($sformatf("v%0d bubble_data", idx), data_out_mem, 0);
      end
      dmem_ack   = 1'b1;
      dmem_rdata = v.rdata;
      #1;
      check($sformatf("v%0d ack_stall", idx), stall_mem, 0);
      step();
      dmem_ack   = 1'b0;
      dmem_rdata = 32'd0;
      check($sformatf("v%0d stall_cycles", idx), stalls, v.waits + 1);
      check($sformatf("v%0d req_drop", idx), dmem_req, 0);
      check($sformatf("v%0d data", idx), data_out_mem, v.exp_data);
      check($sformatf("v%0d rd", idx), rd_2, is_store ? 5'd0 : 5'd7);
      check($sformatf("v%0d r2", idx), instruction_fetched_R2, instr);
      check($sformatf("v%0d no_err", idx), mem_err, 0);
      drive(32'd0, 32'd0, 5'd0, 32'd0);
    end
  endtask

  initial begin : main
    int          req_cnt;
    logic        last_stall;
    logic [31:0] add_instr;
    logic [31:0] addi_instr;

    add_instr  = {7'd0, 5'd2, 5'd1, 3'b000, 5'd5, R_TYPE};
    addi_instr = {12'h001, 5'd1, 3'b000, 5'd9, I_TYPE};

    //           op     f3     addr      rs2           rdata         w  err exp_addr  be    wdata         data
    vecs[0]  = '{LOAD,  F3_B,  32'h103, 32'h0,        32'h80FF0000, 3, 0, 32'h100, 4'hF, 32'h0,        32'hFFFFFF80};
    vecs[1]  = '{LOAD,  F3_BU, 32'h103, 32'h0,        32'h80FF0000, 3, 0, 32'h100, 4'hF, 32'h0,        32'h00000080};
    vecs[2]  = '{LOAD,  F3_B,  32'h101, 32'h0,        32'h1234F67F, 0, 0, 32'h100, 4'hF, 32'h0,        32'hFFFFFFF6};
    vecs[3]  = '{LOAD,  F3_B,  32'h100, 32'h0,        32'h1234F67F, 0, 0, 32'h100, 4'hF, 32'h0,        32'h0000007F};
    vecs[4]  = '{LOAD,  F3_H,  32'h102, 32'h0,        32'h80011234, 0, 0, 32'h100, 4'hF, 32'h0,        32'hFFFF8001};
    vecs[5]  = '{LOAD,  F3_HU, 32'h102, 32'h0,        32'h80011234, 0, 0, 32'h100, 4'hF, 32'h0,        32'h00008001};
    vecs[6]  = '{LOAD,  F3_H,  32'h100, 32'h0,        32'h00007FFF, 0, 0, 32'h100, 4'hF, 32'h0,        32'h00007FFF};
    vecs[7]  = '{LOAD,  F3_W,  32'h104, 32'h0,        32'hDEADBEEF, 2, 0, 32'h104, 4'hF, 32'h0,        32'hDEADBEEF};
    vecs[8]  = '{STORE, F3_B,  32'h301, 32'h123456A5, 32'h0,        0, 0, 32'h300, 4'h2, 32'hA5A5A5A5, 32'h0};
    vecs[9]  = '{STORE, F3_H,  32'h202, 32'hAAAABEEF, 32'h0,        0, 0, 32'h200, 4'hC, 32'hBEEFBEEF, 32'h0};
    vecs[10] = '{STORE, F3_W,  32'h208, 32'hCAFEF00D, 32'h0,        1, 0, 32'h208, 4'hF, 32'hCAFEF00D, 32'h0};
    vecs[11] = '{STORE, F3_H,  32'h300, 32'h00001357, 32'h0,        0, 0, 32'h300, 4'h3, 32'h13571357, 32'h0};
    vecs[12] = '{LOAD,  F3_W,  32'h101, 32'h0,        32'h0,        0, 1, 32'h0,   4'h0, 32'h0,        32'h0};
    vecs[13] = '{LOAD,  3'b011, 32'h100, 32'h0,       32'h0,        0, 1, 32'h0,   4'h0, 32'h0,        32'h0};
    vecs[14] = '{STORE, F3_W,  32'h202, 32'h0,        32'h0,        0, 1, 32'h0,   4'h0, 32'h0,        32'h0};
    vecs[15] = '{STORE, F3_H,  32'h001, 32'h0,        32'h0,        0, 1, 32'h0,   4'h0, 32'h0,        32'h0};
    vecs[16] = '{STORE, 3'b100, 32'h000, 32'h0,       32'h0,        0, 1, 32'h0,   4'h0, 32'h0,        32'h0};
    vecs[17] = '{LOAD,  F3_HU, 32'h103, 32'h0,        32'h0,        0, 1, 32'h0,   4'h0, 32'h0,        32'h0};

    reset      = 1'b1;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'd0;
    drive(32'd0, 32'd0, 5'd0, 32'd0);
    step();
    step();
    check("rst_r2", instruction_fetched_R2, 0);
    check("rst_rd", rd_2, 0);
    check("rst_data", data_out_mem, 0);
    check("rst_err", mem_err, 0);
    check("rst_req", dmem_req, 0);
    check("rst_we", dmem_we, 0);
    check("rst_addr", dmem_addr, 0);
    check("rst_be", dmem_be, 0);
    check("rst_wdata", dmem_wdata, 0);
    check("rst_stall", stall_mem, 0);
    reset = 1'b0;

    // Non-memory pass-through, one edge of latency
    drive(add_instr, 32'h12345678, 5'd5, 32'hFFFFFFFF);
    #1;
    check("add_stall", stall_mem, 0);
    step();
    check("add_data", data_out_mem, 32'h12345678);
    check("add_rd", rd_2, 5);
    check("add_r2", instruction_fetched_R2, add_instr);
    check("add_req", dmem_req, 0);
    drive(addi_instr, 32'hFFFFFFFF, 5'd31, 32'd0);
    #1;
    check("addi_stall", stall_mem, 0);
    step();
    check("addi_data", data_out_mem, 32'hFFFFFFFF);
    check("addi_rd", rd_2, 31);
    check("addi_err", mem_err, 0);

    for (int i = 0; i < 18; i++) run_mem(i, vecs[i]);

    // Timeout: LW never acknowledged
    drive(enc(LOAD, F3_W), 32'h40, 5'd7, 32'd0);
    #1;
    check("to_stall0", stall_mem, 1);
    step();
    check("to_addr", dmem_addr, 32'h40);
    req_cnt    = 0;
    last_stall = 1'b1;
    while (dmem_req === 1'b1 && req_cnt < 20) begin
      req_cnt++;
      last_stall = stall_mem;
      step();
    end
    check("to_req_cycles", req_cnt, 4);
    check("to_last_stall", last_stall, 0);
    check("to_err", mem_err, 1);
    check("to_rd", rd_2, 0);
    check("to_data", data_out_mem, 0);
    drive(add_instr, 32'h0BADF00D, 5'd9, 32'd0);
    step();
    check("to_add_data", data_out_mem, 32'h0BADF00D);
    check("to_add_rd", rd_2, 9);
    check("to_err_once", mem_err, 0);
    check("to_add_req", dmem_req, 0);

    // Reset during the second REQ cycle, late ack afterwards
    drive(enc(LOAD, F3_W), 32'h80, 5'd7, 32'd0);
    step();
    check("ra_req1", dmem_req, 1);
    step();
    check("ra_req2", dmem_req, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(32'd0, 32'd0, 5'd0, 32'd0);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hFFFFFFFF;
    #1;
    check("ra_req_off", dmem_req, 0);
    check("ra_addr", dmem_addr, 0);
    check("ra_be", dmem_be, 0);
    check("ra_r2", instruction_fetched_R2, 0);
    check("ra_stall", stall_mem, 0);
    step();
    dmem_ack   = 1'b0;
    dmem_rdata = 32'd0;
    check("ra_late_req", dmem_req, 0);
    check("ra_late_err", mem_err, 0);
    check("ra_late_rd", rd_2, 0);
    check("ra_late_data", data_out_mem, 0);
    drive(add_instr, 32'h000055AA, 5'd3, 32'd0);
    step();
    check("ra_add_data", data_out_mem, 32'h000055AA);
    check("ra_add_rd", rd_2, 3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
